// File: rtl/pcc_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcc_frame_loader                                             |
// | Description : Bit-serial to parallel front end for the popcount-compare    |
// |               classifier. Frames a valid/ready serial stream into the      |
// |               pos/neg feature vectors, holds each frame until accepted,    |
// |               flags framing errors and resynchronises on s_last.           |
// |               Optional macro PCC_LOADER_PARITY_EN adds a trailing          |
// |               even-parity beat to every frame.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcc_frame_loader #(
  parameter int N_POS = 1,
  parameter int N_NEG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bit,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_POS-1:0] pos,
  output logic [N_NEG-1:0] neg,
  output logic             frame_err
);

  localparam int c_FRAME_LEN = N_POS + N_NEG;
  localparam int c_CW        = $clog2(c_FRAME_LEN + 1);
`ifdef PCC_LOADER_PARITY_EN
  // One extra trailing beat carries the even-parity bit.
  localparam int c_BEATS     = c_FRAME_LEN + 1;
`else
  localparam int c_BEATS     = c_FRAME_LEN;
`endif

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CW-1:0]        r_cnt;
  logic [c_CW-1:0]        w_cnt_nxt;
  logic [c_FRAME_LEN-1:0] r_vec;
  logic [c_FRAME_LEN-1:0] w_vec_nxt;
  logic                   r_err;
  logic                   w_err_nxt;
  logic                   w_accept;
  logic                   w_last_beat;
  logic                   w_par_ok;

  assign s_ready     = (r_state != S_HOLD);
  assign m_valid     = (r_state == S_HOLD);
  assign frame_err   = r_err;
  assign pos         = r_vec[N_POS-1:0];
  assign neg         = r_vec[c_FRAME_LEN-1:N_POS];

  assign w_accept    = s_valid && s_ready;
  assign w_last_beat = (r_cnt == c_CW'(c_BEATS - 1));

`ifdef PCC_LOADER_PARITY_EN
  // Feature bits XOR parity bit must be zero for even parity.
  assign w_par_ok    = ~^{r_vec, s_bit};
`else
  assign w_par_ok    = 1'b1;
`endif

  // State, counter, vector and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic: beat capture, framing checks and handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          // Parity beat (index c_FRAME_LEN) matches no slot and writes nothing.
          for (int i = 0; i < c_FRAME_LEN; i++) begin
            if (r_cnt == c_CW'(i)) w_vec_nxt[i] = s_bit;
          end
          if (w_last_beat) begin
            w_cnt_nxt = '0;
            if (!s_last) begin
              // Long frame: discard and skip to the next s_last.
              w_err_nxt   = 1'b1;
              w_vec_nxt   = '0;
              w_state_nxt = S_DROP;
            end else if (!w_par_ok) begin
              w_err_nxt   = 1'b1;
              w_vec_nxt   = '0;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else if (s_last) begin
            // Short frame: discard and restart immediately.
            w_err_nxt = 1'b1;
            w_vec_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end
        end
      end
      S_DROP: begin
        if (w_accept && s_last) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (m_ready) w_state_nxt = S_LOAD;
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pcc_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pcc_frame_loader                                          |
// | Description : Directed self-checking bench for pcc_frame_loader            |
// |               (default N_POS=1, N_NEG=2). Honours PCC_LOADER_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pcc_frame_loader;

`ifdef PCC_LOADER_PARITY_EN
  localparam int c_BEATS = 4;
`else
  localparam int c_BEATS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic       s_bit;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [0:0] pos;
  logic [1:0] neg;
  logic       frame_err;

  int n_pass  = 0;
  int n_total = 0;

  pcc_frame_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_bit     (s_bit),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .pos       (pos),
    .neg       (neg),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one beat for one clock edge; returns 1 time unit after the edge.
  task automatic send(input logic b, input logic last);
    s_valid = 1'b1;
    s_bit   = b;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_bit   = 1'b0;
    s_last  = 1'b0;
  endtask

  // Clean three-feature frame, with the parity beat appended when enabled.
  task automatic frame3(input logic b0, input logic b1, input logic b2);
    send(b0, 1'b0);
    send(b1, 1'b0);
`ifdef PCC_LOADER_PARITY_EN
    send(b2, 1'b0);
    send(b0 ^ b1 ^ b2, 1'b1);
`else
    send(b2, 1'b1);
`endif
  endtask

  task automatic expect_frame(input string tag, input logic p, input logic [1:0] n);
    check({tag, "_mvalid"}, m_valid, 1);
    check({tag, "_pos"}, pos, p);
    check({tag, "_neg"}, neg, n);
    check({tag, "_sready"}, s_ready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] long_bits;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_bit   = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", m_valid, 0);
    check("rst_pos", pos, 0);
    check("rst_neg", neg, 0);
    check("rst_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sready", s_ready, 1);

    // Basic frame 1,0,1 with m_ready=1: one-cycle m_valid
    frame3(1'b1, 1'b0, 1'b1);
    expect_frame("basic", 1'b1, 2'b10);
    check("basic_err", frame_err, 0);
    @(posedge clk);
    #1;
    check("basic_mvalid_fall", m_valid, 0);
    check("basic_sready_back", s_ready, 1);

    // Back-pressure: hold for 5 cycles while upstream tries to push
    m_ready = 1'b0;
    frame3(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_bit   = 1'b0;
      s_last  = 1'b1;
      @(posedge clk);
      #1;
      expect_frame("hold", 1'b1, 2'b10);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    check("hold_sready_mready_cycle", s_ready, 0);
    @(posedge clk);
    #1;
    check("hold_release_mvalid", m_valid, 0);
    check("hold_release_err", frame_err, 0);

    // Short frame 1,1 then clean frame 0,1,1
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check("short_err", frame_err, 1);
    check("short_mvalid", m_valid, 0);
    check("short_pos_clr", pos, 0);
    check("short_neg_clr", neg, 0);
    frame3(1'b0, 1'b1, 1'b1);
    expect_frame("after_short", 1'b0, 2'b11);
    check("after_short_err", frame_err, 0);
    @(posedge clk);
    #1;

    // Long frame 1,0,1,0,0 with s_last on beat 5 then clean 1,1,0
    long_bits = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      send(long_bits[i], (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("long_err_b%0d", i), frame_err, (i == c_BEATS - 1) ? 1 : 0);
      check($sformatf("long_mvalid_b%0d", i), m_valid, 0);
    end
    frame3(1'b1, 1'b1, 1'b0);
    expect_frame("after_long", 1'b1, 2'b01);
    @(posedge clk);
    #1;

    // Reset after two beats
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("midrst_partial_pos", pos, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pos", pos, 0);
    check("midrst_neg", neg, 0);
    check("midrst_mvalid", m_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame3(1'b0, 1'b0, 1'b1);
    expect_frame("after_midrst", 1'b0, 2'b10);
    @(posedge clk);
    #1;

    // Reset during HOLD
    m_ready = 1'b0;
    frame3(1'b1, 1'b1, 1'b1);
    expect_frame("pre_holdrst", 1'b1, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("holdrst_mvalid", m_valid, 0);
    check("holdrst_pos", pos, 0);
    check("holdrst_neg", neg, 0);
    check("holdrst_sready", s_ready, 1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    frame3(1'b0, 1'b0, 1'b1);
    expect_frame("after_holdrst", 1'b0, 2'b10);
    @(posedge clk);
    #1;

`ifdef PCC_LOADER_PARITY_EN
    // Bad parity: 1,0,1 with parity bit 1
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check("par_bad_err", frame_err, 1);
    check("par_bad_mvalid", m_valid, 0);
    check("par_bad_neg", neg, 0);
    @(posedge clk);
    #1;
    check("par_bad_err_fall", frame_err, 0);
    check("par_bad_mvalid_after", m_valid, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcc_frame_loader.md
Name: pcc_frame_loader

Overview:
- Serial-to-parallel front end for the popcount-compare (pcc) classifier.
- Accepts a bit-serial feature frame on a valid/ready stream and splits it into the parallel `pos` and `neg` vectors that the comparator consumes.
- Holds each frame stable until the downstream side accepts it.
- Frames the stream, detects framing errors, and resynchronises on `s_last`.

Parameters:
- N_POS, 1, width of the positive-feature vector.
- N_NEG, 2, width of the negative-feature vector.
- Local FRAME_LEN = N_POS+N_NEG; counter width CW = $clog2(FRAME_LEN+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  serial beat valid.
- s_ready  output  1  loader can accept a beat.
- s_bit  input  1  feature bit.
- s_last  input  1  marks the final beat of a frame.
- m_valid  output  1  `pos`/`neg` hold a complete frame.
- m_ready  input  1  downstream accepts the frame.
- pos  output  N_POS  positive feature vector.
- neg  output  N_NEG  negative feature vector.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async assert, sync release):
  - State = LOAD; bit counter = 0.
  - `pos` = 0, `neg` = 0.
  - `m_valid` = 0, `frame_err` = 0.
  - `s_ready` = 1 once out of reset.
- A beat is accepted when s_valid && s_ready.
- Bit order: the first N_POS beats fill `pos[0..N_POS-1]` LSB first; the next N_NEG beats fill `neg[0..N_NEG-1]` LSB first.
- States:
  - LOAD (s_ready=1, m_valid=0):
    - Each accepted beat writes the indexed bit and increments the counter.
    - If the beat is beat FRAME_LEN-1 and s_last=1: go to HOLD; counter -> 0.
    - If s_last=1 on any earlier beat: pulse frame_err, clear `pos`/`neg`, counter -> 0, stay in LOAD (short frame discarded).
    - If the beat is beat FRAME_LEN-1 and s_last=0: pulse frame_err, clear vectors, go to DROP.
  - DROP (s_ready=1, m_valid=0):
    - Accepted beats are discarded.
    - An accepted beat with s_last=1 returns the FSM to LOAD with counter=0.
  - HOLD (s_ready=0, m_valid=1):
    - `pos`/`neg` are frozen.
    - On m_ready=1: m_valid falls next cycle; go to LOAD.
    - No same-cycle bypass: s_ready stays 0 in the m_ready cycle.
    - Sustained throughput is one frame per FRAME_LEN+1 cycles.
- Latency: m_valid rises on the clock edge that accepts the last beat, i.e. it is visible the cycle after that beat.
- While in HOLD, `s_valid` is ignored; the upstream must stall.
- Vectors in LOAD are partial and must not be used; consumers qualify with m_valid.
- frame_err is a registered one-cycle pulse; back-to-back errors produce back-to-back pulses.
- Reset mid-frame: partial frame lost, all outputs cleared immediately.
- Reset in HOLD: m_valid drops asynchronously.
- Zero-width vectors are illegal (N_POS, N_NEG >= 1).

Optional Feature:
- Macro: PCC_LOADER_PARITY_EN.
- Defined:
  - The frame carries one extra trailing beat, an even-parity bit over all FRAME_LEN feature bits; s_last is expected on that beat (frame = FRAME_LEN+1 beats).
  - On parity mismatch: pulse frame_err, clear vectors, return to LOAD; nothing is presented.
  - Short and long frames are handled exactly as above against the extended length.
- Undefined: no parity beat; behaviour exactly as in Behaviour.

Test Plan:
- Defaults; beats 1,0,1 with s_last on beat 3; m_ready=1 -> pos=1'b1, neg=2'b10, m_valid high exactly one cycle after beat 3, low the following cycle.
- Same frame with m_ready=0 for 5 cycles -> m_valid and pos=1/neg=2'b10 stable; s_ready=0 throughout; s_valid beats not consumed; released on m_ready.
- Beats 1,1 with s_last on beat 2 -> frame_err one pulse, no m_valid; next frame 0,1,1 -> pos=0, neg=2'b11.
- Beats 1,0,1 with no s_last, then 0,0 with s_last on the 5th beat -> frame_err on beat 3, DROP; next clean frame 1,1,0 -> pos=1, neg=2'b01.
- Assert rst_n=0 after 2 beats, or during HOLD -> outputs zero immediately, m_valid=0; after release, frame 0,0,1 -> pos=0, neg=2'b10.
- With PCC_LOADER_PARITY_EN: 1,0,1,parity 0 -> accepted; 1,0,1,parity 1 -> frame_err, no m_valid.
